// File: rtl/fetch_pkg.sv
// Shared constants for the fetch/PC stage: phase bit indices, HLT encoding
// fields and the default datapath width.
package fetch_pkg;

  localparam int DEF_WIDTH = 16;

  localparam int PH_F = 0;
  localparam int PH_R = 1;
  localparam int PH_X = 2;
  localparam int PH_M = 3;
  localparam int PH_W = 4;

  localparam logic [1:0] HLT_OP = 2'b11;
  localparam logic [3:0] HLT_FN = 4'b1111;

  function automatic logic is_hlt_word(input logic [15:0] word);
    return (word[15:14] == HLT_OP) && (word[7:4] == HLT_FN);
  endfunction

endpackage

// File: rtl/fetch_icount.sv
// 32-bit retired-instruction counter; wraps from all-ones to zero.
module fetch_icount (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 32'd0;
    end else if (inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / program-counter stage driven by a one-hot phase vector.
// Optional retired-instruction counter enabled with FETCH_ICOUNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       phase,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic             hlt,
  output logic             phase_err
`ifdef FETCH_ICOUNT_EN
  ,
  output logic [31:0]      icount
`endif
);

  logic [WIDTH-1:0] npc;
  logic             ph_illegal;
  logic             do_f;
  logic             do_w;
  logic             fetch_hlt;

  // More than one phase bit set: the cycle is discarded except for the flag.
  assign ph_illegal = (phase & (phase - 5'd1)) != 5'd0;
  assign do_f       = !ph_illegal && phase[PH_F];
  assign do_w       = !ph_illegal && phase[PH_W];
  assign fetch_hlt  = is_hlt_word(imem_rdata[15:0]);
  assign imem_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      ir        <= '0;
      npc       <= '0;
      hlt       <= 1'b0;
      phase_err <= 1'b0;
    end else if (ph_illegal) begin
      phase_err <= 1'b1;
    end else begin
      if (do_f) begin
        ir  <= imem_rdata;
        npc <= pc + 1'b1;
        if (fetch_hlt) begin
          hlt <= 1'b1;
        end
      end
      // A halted core keeps its PC parked on the HLT instruction.
      if (do_w && !hlt) begin
        pc <= br_taken ? br_target : npc;
      end
    end
  end

`ifdef FETCH_ICOUNT_EN
  fetch_icount u_icount (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_w && !hlt),
    .count (icount)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: instruction-level reference model,
// directed scenarios plus a randomized instruction stream.
module tb_fetch_unit;

  localparam logic [4:0] PF = 5'b00001;
  localparam logic [4:0] PR = 5'b00010;
  localparam logic [4:0] PX = 5'b00100;
  localparam logic [4:0] PM = 5'b01000;
  localparam logic [4:0] PW = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  phase = 5'd0;
  logic [15:0] imem_rdata = 16'd0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'd0;
  logic [15:0] imem_addr, pc, ir;
  logic        hlt, phase_err;
  logic [15:0] imem_addr_w, pc_w, ir_w;
  logic        hlt_w, phase_err_w;
`ifdef FETCH_ICOUNT_EN
  logic [31:0] icount, icount_w;
`endif

  int checks = 0;
  int errors = 0;

  // Instruction-level reference state
  logic [15:0] m_pc, m_ir;
  logic        m_hlt, m_perr;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .phase(phase), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .ir(ir), .hlt(hlt), .phase_err(phase_err)
`ifdef FETCH_ICOUNT_EN
    , .icount(icount)
`endif
  );

  fetch_unit #(.WIDTH(16), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .phase(phase), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target),
    .pc(pc_w), .ir(ir_w), .hlt(hlt_w), .phase_err(phase_err_w)
`ifdef FETCH_ICOUNT_EN
    , .icount(icount_w)
`endif
  );

  function automatic logic hlt_word(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  task automatic cycle(input logic [4:0] ph);
    phase = ph;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(5'd0);
    rst = 1'b0;
    m_pc = 16'h0000; m_ir = 16'h0000; m_hlt = 1'b0; m_perr = 1'b0; m_cnt = 32'd0;
  endtask

  // One full instruction F..W (HLT words stop after R, as the generator would).
  task automatic run_instr(input logic [15:0] word, input logic taken, input logic [15:0] tgt,
                           input string tag);
    checks++;
    if (imem_addr !== m_pc) begin
      errors++; $display("FAIL %s addr: got %h expected %h", tag, imem_addr, m_pc);
    end
    imem_rdata = word;
    cycle(PF);
    imem_rdata = 16'($urandom);
    m_ir = word;
    if (hlt_word(word)) m_hlt = 1'b1;
    checks++;
    if (ir !== m_ir || hlt !== m_hlt) begin
      errors++; $display("FAIL %s fetch: got ir=%h hlt=%b expected ir=%h hlt=%b", tag, ir, hlt, m_ir, m_hlt);
    end
    if (hlt_word(word)) begin
      cycle(PR);
      cycle(5'd0);
      cycle(5'd0);
    end else begin
      cycle(PR);
      cycle(PX);
      cycle(PM);
      br_taken = taken;
      br_target = tgt;
      cycle(PW);
      br_taken = 1'b0;
      br_target = 16'($urandom);
      if (!m_hlt) begin
        m_pc = taken ? tgt : m_pc + 16'd1;
        m_cnt = m_cnt + 32'd1;
      end
    end
    checks++;
    if (pc !== m_pc || ir !== m_ir || hlt !== m_hlt) begin
      errors++; $display("FAIL %s end: got pc=%h ir=%h hlt=%b expected pc=%h ir=%h hlt=%b",
                         tag, pc, ir, hlt, m_pc, m_ir, m_hlt);
    end
`ifdef FETCH_ICOUNT_EN
    checks++;
    if (icount !== m_cnt) begin
      errors++; $display("FAIL %s icount: got %0d expected %0d", tag, icount, m_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || hlt !== 1'b0 || phase_err !== 1'b0 || imem_addr !== 16'h0000) begin
      errors++; $display("FAIL reset: got pc=%h ir=%h hlt=%b perr=%b addr=%h expected all zero",
                         pc, ir, hlt, phase_err, imem_addr);
    end
    checks++;
    if (pc_w !== 16'hFFFF || imem_addr_w !== 16'hFFFF || ir_w !== 16'h0000 || hlt_w !== 1'b0 || phase_err_w !== 1'b0) begin
      errors++; $display("FAIL reset_pc_param: got pc=%h addr=%h expected ffff", pc_w, imem_addr_w);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    run_instr(16'h1234, 1'b0, 16'h7777, "seq0");
    run_instr(16'h2345, 1'b0, 16'h7777, "seq1");
    run_instr(16'h3456, 1'b0, 16'h7777, "seq2");
    checks++;
    if (pc !== 16'h0003) begin
      errors++; $display("FAIL seq_pc: got %h expected 0003", pc);
    end
`ifdef FETCH_ICOUNT_EN
    checks++;
    if (icount !== 32'd3) begin
      errors++; $display("FAIL seq_icount: got %0d expected 3", icount);
    end
`endif
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(16'h4000, 1'b1, 16'h0040, "branch");
    checks++;
    if (imem_addr !== 16'h0040) begin
      errors++; $display("FAIL branch_addr: got %h expected 0040", imem_addr);
    end
    run_instr(16'h0101, 1'b0, 16'h0999, "after_branch");
  endtask

  task automatic test_phase_err();
    logic [15:0] pc_s, ir_s;
    do_reset();
    run_instr(16'h5A5A, 1'b0, 16'h0000, "perr_pre");
    pc_s = pc; ir_s = ir;
    imem_rdata = 16'hBEEF;
    br_taken = 1'b1;
    br_target = 16'h0F0F;
    cycle(5'b00101);
    br_taken = 1'b0;
    checks++;
    if (phase_err !== 1'b1 || pc !== pc_s || ir !== ir_s) begin
      errors++; $display("FAIL phase_err: got perr=%b pc=%h ir=%h expected 1 %h %h", phase_err, pc, ir, pc_s, ir_s);
    end
    cycle(5'b10001);
    cycle(5'd0);
    checks++;
    if (phase_err !== 1'b1 || pc !== pc_s || ir !== ir_s) begin
      errors++; $display("FAIL phase_err_sticky: got perr=%b pc=%h ir=%h expected 1 %h %h", phase_err, pc, ir, pc_s, ir_s);
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    cycle(5'b00011);
    run_instr(16'h0011, 1'b1, 16'h0012, "mid_pre");
    imem_rdata = 16'hFFF7;
    cycle(PF);
    cycle(PR);
    checks++;
    if (pc !== 16'h0012 || hlt !== 1'b1 || phase_err !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got pc=%h hlt=%b perr=%b expected 0012 1 1", pc, hlt, phase_err);
    end
    rst = 1'b1;
    cycle(PX);
    rst = 1'b0;
    checks++;
    if (pc !== 16'h0000 || ir !== 16'h0000 || hlt !== 1'b0 || phase_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got pc=%h ir=%h hlt=%b perr=%b expected 0000 0000 0 0", pc, ir, hlt, phase_err);
    end
    m_pc = 16'h0000; m_ir = 16'h0000; m_hlt = 1'b0; m_perr = 1'b0; m_cnt = 32'd0;
  endtask

  task automatic test_hlt();
    do_reset();
    run_instr(16'h0A0A, 1'b1, 16'h0005, "hlt_pre");
    run_instr(16'hC0F0, 1'b0, 16'h0000, "hlt");
    checks++;
    if (hlt !== 1'b1 || pc !== 16'h0005) begin
      errors++; $display("FAIL hlt_hold: got hlt=%b pc=%h expected 1 0005", hlt, pc);
    end
    br_taken = 1'b1;
    br_target = 16'h1234;
    cycle(PW);
    br_taken = 1'b0;
    checks++;
    if (hlt !== 1'b1 || pc !== 16'h0005) begin
      errors++; $display("FAIL hlt_freeze_w: got hlt=%b pc=%h expected 1 0005", hlt, pc);
    end
`ifdef FETCH_ICOUNT_EN
    checks++;
    if (icount !== 32'd1) begin
      errors++; $display("FAIL hlt_icount: got %0d expected 1", icount);
    end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(16'h0707, 1'b0, 16'h0000, "wrap_main");
    checks++;
    if (pc_w !== 16'h0000 || imem_addr_w !== 16'h0000 || ir_w !== 16'h0707) begin
      errors++; $display("FAIL wrap: got pc=%h ir=%h expected 0000 0707", pc_w, ir_w);
    end
    run_instr(16'h0808, 1'b1, 16'hFFFF, "wrap_to_top");
    run_instr(16'h0909, 1'b0, 16'h1111, "wrap_from_top");
  endtask

  task automatic test_random();
    logic [15:0] w;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      if (hlt_word(w)) w[14] = 1'b0;
      run_instr(w, 1'($urandom_range(0, 1)), 16'($urandom), "rand");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        imem_rdata = 16'($urandom);
        cycle(5'd0);
      end
      checks++;
      if (pc !== m_pc || ir !== m_ir) begin
        errors++; $display("FAIL rand_idle: got pc=%h ir=%h expected %h %h", pc, ir, m_pc, m_ir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_phase_err();
    test_rst_mid();
    test_random();
    test_hlt();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
